ifu_ctrl: RTL and testbench



---
 rtl/ifu_if.sv | 37 +++
 rtl/ifu_ctrl.sv | 96 +++++++++
 tb/tb_ifu_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_if.sv
// Fetch-sequencer bus bundle: PC register controls, IMEM handshake and decode/execute hand-off.
// The master side belongs to ifu_ctrl; the slave side is the surrounding core (or a bench).
interface ifu_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] pc;
    logic             pc_wen;
    logic             pc_jen;
    logic [WIDTH-1:0] pc_din;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_addr;
    logic             resp_valid;
    logic [WIDTH-1:0] resp_data;
    logic             resp_err;
    logic             inst_valid;
    logic [WIDTH-1:0] inst;
    logic             exec_done;
    logic             jump_en;
    logic [WIDTH-1:0] jump_target;
    logic             halted;
    logic [1:0]       halt_cause;

    modport master (
        input  pc, req_ready, resp_valid, resp_data, resp_err,
               exec_done, jump_en, jump_target,
        output pc_wen, pc_jen, pc_din, req_valid, req_addr,
               inst_valid, inst, halted, halt_cause
    );

    modport slave (
        output pc, req_ready, resp_valid, resp_data, resp_err,
               exec_done, jump_en, jump_target,
        input  pc_wen, pc_jen, pc_din, req_valid, req_addr,
               inst_valid, inst, halted, halt_cause
    );
endinterface

// File: rtl/ifu_ctrl.sv
// Instruction-fetch sequencer: IDLE -> REQ -> WAIT -> EXEC -> UPDATE loop with sticky HALT.
// Define IFU_ALIGN_CHECK_EN to halt (cause 3) on taken jumps to non-word-aligned targets.
module ifu_ctrl #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input logic   clk,
    input logic   rst,
    ifu_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, REQ, WAIT, EXEC, UPDATE, HALT
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [7:0] to_cnt;
    logic [1:0] cause_nxt;
    logic       misalign;

`ifdef IFU_ALIGN_CHECK_EN
    assign misalign = bus.jump_en && (bus.jump_target[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        cause_nxt = 2'd0;
        case (state)
            IDLE:   state_nxt = REQ;
            REQ:    if (bus.req_ready) state_nxt = WAIT;
            WAIT: begin
                // a response in the last allowed cycle still wins over the timeout
                if (bus.resp_valid) begin
                    if (bus.resp_err) begin
                        state_nxt = HALT;
                        cause_nxt = 2'd1;
                    end else begin
                        state_nxt = EXEC;
                    end
                end else if (to_cnt == TO_LAST) begin
                    state_nxt = HALT;
                    cause_nxt = 2'd2;
                end
            end
            EXEC: begin
                if (bus.exec_done) begin
                    if (misalign) begin
                        state_nxt = HALT;
                        cause_nxt = 2'd3;
                    end else begin
                        state_nxt = UPDATE;
                    end
                end
            end
            UPDATE: state_nxt = REQ;
            HALT:   state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            to_cnt         <= '0;
            bus.inst       <= '0;
            bus.pc_jen     <= 1'b0;
            bus.pc_din     <= '0;
            bus.halt_cause <= 2'd0;
        end else begin
            state <= state_nxt;
            // held at zero outside WAIT so every WAIT visit starts from a cleared count
            if (state != WAIT)
                to_cnt <= '0;
            else if (to_cnt != 8'hff)
                to_cnt <= to_cnt + 8'd1;
            if (state == WAIT && bus.resp_valid && !bus.resp_err)
                bus.inst <= bus.resp_data;
            if (state == EXEC && bus.exec_done) begin
                bus.pc_jen <= bus.jump_en;
                bus.pc_din <= bus.jump_target;
            end
            if (state != HALT && state_nxt == HALT)
                bus.halt_cause <= cause_nxt;
        end
    end

    // pc is itself a register output, so forwarding it keeps every output flop- or state-driven
    assign bus.req_addr   = bus.pc;
    assign bus.req_valid  = (state == REQ);
    assign bus.inst_valid = (state == EXEC);
    assign bus.pc_wen     = (state == UPDATE);
    assign bus.halted     = (state == HALT);
endmodule

// File: tb/tb_ifu_ctrl.sv
// Randomized bench for ifu_ctrl: a transaction-level timeline model predicts every output each cycle.
module tb_ifu_ctrl;
    localparam int TO = 4;
    localparam logic [31:0] PC_RST = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst;
    logic [31:0] pc_q;

    ifu_if #(.WIDTH(32)) bus ();

    ifu_ctrl #(.WIDTH(32), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // environment PC register
    always @(posedge clk) begin
        if (!rst) pc_q <= PC_RST;
        else if (bus.pc_wen) pc_q <= bus.pc_jen ? bus.pc_din : pc_q + 32'd4;
    end
    assign bus.pc = pc_q;

    typedef struct packed {
        logic        rv;
        logic [31:0] addr;
        logic        iv;
        logic [31:0] inst;
        logic        wen;
        logic        jen;
        logic [31:0] din;
        logic        hlt;
        logic [1:0]  cause;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   rise_q[$];
    logic prev_rv = 1'b0;

    logic [31:0] m_pc, m_inst, m_din;
    logic        m_jen;
    logic [1:0]  m_cause;

    always @(negedge clk) begin
        exp_t e, g;
        if (q.size() > 0) begin
            e = q.pop_front();
            g = '{bus.req_valid, bus.req_addr, bus.inst_valid, bus.inst, bus.pc_wen,
                  bus.pc_jen, bus.pc_din, bus.halted, bus.halt_cause};
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL cycle%0d outputs: got rv=%b addr=%h iv=%b inst=%h wen=%b jen=%b din=%h hlt=%b cause=%0d ; want rv=%b addr=%h iv=%b inst=%h wen=%b jen=%b din=%h hlt=%b cause=%0d",
                         cyc, g.rv, g.addr, g.iv, g.inst, g.wen, g.jen, g.din, g.hlt, g.cause,
                         e.rv, e.addr, e.iv, e.inst, e.wen, e.jen, e.din, e.hlt, e.cause);
            end
        end
        if (bus.req_valid === 1'b1 && prev_rv !== 1'b1) rise_q.push_back(cyc);
        prev_rv = bus.req_valid;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    function automatic exp_t mk(input logic rv, input logic iv, input logic wen, input logic hlt);
        exp_t e;
        e = '{rv, m_pc, iv, m_inst, wen, m_jen, m_din, hlt, m_cause};
        return e;
    endfunction

    task automatic model_reset();
        m_pc = PC_RST; m_inst = '0; m_din = '0; m_jen = 1'b0; m_cause = 2'd0;
    endtask

    // inputs the DUT must ignore in the current state get random values
    task automatic noise();
        bus.req_ready   = 1'($urandom_range(0, 1));
        bus.resp_valid  = 1'($urandom_range(0, 1));
        bus.resp_err    = 1'($urandom_range(0, 1));
        bus.resp_data   = $urandom;
        bus.exec_done   = 1'($urandom_range(0, 1));
        bus.jump_en     = 1'($urandom_range(0, 1));
        bus.jump_target = $urandom;
    endtask

    task automatic step(input exp_t e);
        q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic req_phase(input int dr);
        for (int i = 0; i <= dr; i++) begin
            noise();
            bus.req_ready = (i == dr);
            step(mk(1, 0, 0, 0));
        end
    endtask

    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            noise();
            step(mk(0, 0, 0, 1));
        end
    endtask

    // reset asserted during the current cycle (whose outputs are e), then an IDLE cycle with a late response
    task automatic reset_now(input exp_t e);
        noise();
        rst = 1'b0;
        step(e);
        model_reset();
        rst = 1'b1;
        noise();
        bus.resp_valid = 1'b1;
        bus.resp_err   = 1'b0;
        step(mk(0, 0, 0, 0));
    endtask

    task automatic inst_txn(input int dr, input int dw, input int de, input logic jen,
                            input logic [31:0] tgt, input logic [31:0] data);
        logic mis;
        req_phase(dr);
        for (int i = 0; i <= dw; i++) begin
            noise();
            bus.resp_valid = (i == dw);
            bus.resp_err   = 1'b0;
            if (i == dw) bus.resp_data = data;
            step(mk(0, 0, 0, 0));
        end
        m_inst = data;
        for (int i = 0; i <= de; i++) begin
            noise();
            bus.exec_done = (i == de);
            if (i == de) begin
                bus.jump_en     = jen;
                bus.jump_target = tgt;
            end
            step(mk(0, 1, 0, 0));
        end
        m_jen = jen;
        m_din = tgt;
`ifdef IFU_ALIGN_CHECK_EN
        mis = jen && (tgt[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        if (mis) begin
            m_cause = 2'd3;
        end else begin
            noise();
            step(mk(0, 0, 1, 0));
            m_pc = jen ? tgt : m_pc + 32'd4;
        end
    endtask

    initial begin
        int d;
        model_reset();
        noise();
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            noise();
            step(mk(0, 0, 0, 0));
        end
        noise();
        rst = 1'b1;
        step(mk(0, 0, 0, 0));
        chk("first_req_valid", {31'd0, bus.req_valid}, 32'd1);
        chk("first_req_addr", bus.req_addr, 32'h8000_0000);

        // straight-line fetch, minimum loop
        for (int i = 0; i < 3; i++) inst_txn(0, 0, 0, 1'b0, $urandom, $urandom);
        chk("loop_period", rise_q[rise_q.size()-1] - rise_q[rise_q.size()-2], 32'd4);
        chk("seq_pc", bus.req_addr, 32'h8000_000C);

        // backpressure, then jump
        inst_txn(5, 1, 2, 1'b0, $urandom, 32'h1234_5678);
        chk("bp_inst_hold", bus.inst, 32'h1234_5678);
        inst_txn(0, 0, 0, 1'b1, 32'h8000_0100, $urandom);
        chk("jump_addr", bus.req_addr, 32'h8000_0100);
        chk("jump_din", bus.pc_din, 32'h8000_0100);
        chk("jump_jen", {31'd0, bus.pc_jen}, 32'd1);

        // response in the last cycle before timeout
        inst_txn(0, TO - 1, 0, 1'b0, $urandom, $urandom);

        // misaligned target
        inst_txn(0, 0, 0, 1'b1, 32'h8000_0102, $urandom);
`ifdef IFU_ALIGN_CHECK_EN
        chk("misalign_cause", {30'd0, bus.halt_cause}, 32'd3);
        halt_cycles(4);
        reset_now(mk(0, 0, 0, 1));
`else
        chk("misalign_addr", bus.req_addr, 32'h8000_0102);
`endif

        // randomized transactions
        for (int i = 0; i < 40; i++) begin
            inst_txn($urandom_range(0, 3), $urandom_range(0, TO - 1), $urandom_range(0, 3),
                     1'($urandom_range(0, 1)), {16'h8000, 16'($urandom) & 16'hfffc}, $urandom);
        end

        // reset in WAIT with a late response
        req_phase(1);
        d = $urandom_range(0, 2);
        for (int i = 0; i < d; i++) begin
            noise();
            bus.resp_valid = 1'b0;
            step(mk(0, 0, 0, 0));
        end
        reset_now(mk(0, 0, 0, 0));
        chk("rst_wait_iv", {31'd0, bus.inst_valid}, 32'd0);
        chk("rst_wait_inst", bus.inst, 32'd0);
        inst_txn(0, 0, 1, 1'b0, $urandom, $urandom);

        // bus error
        req_phase(2);
        noise();
        bus.resp_valid = 1'b0;
        step(mk(0, 0, 0, 0));
        noise();
        bus.resp_valid = 1'b1;
        bus.resp_err   = 1'b1;
        step(mk(0, 0, 0, 0));
        m_cause = 2'd1;
        chk("err_cause", {30'd0, bus.halt_cause}, 32'd1);
        chk("err_halted", {31'd0, bus.halted}, 32'd1);
        halt_cycles(10);
        reset_now(mk(0, 0, 0, 1));

        // timeout
        inst_txn(0, 0, 0, 1'b0, $urandom, $urandom);
        req_phase(0);
        for (int i = 0; i < TO; i++) begin
            noise();
            bus.resp_valid = 1'b0;
            step(mk(0, 0, 0, 0));
        end
        m_cause = 2'd2;
        chk("to_cause", {30'd0, bus.halt_cause}, 32'd2);
        halt_cycles(10);
        chk("to_no_req", {31'd0, bus.req_valid}, 32'd0);
        reset_now(mk(0, 0, 0, 1));
        inst_txn(1, 1, 1, 1'b1, 32'h8000_0040, $urandom);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
